// File: rtl/ice40_reset_sequencer.sv
// Central reset sequencer: holds all domains in reset, then releases them in order.
// Optional watchdog request source is built only when ICE40_RESET_WDT_EN is defined.
module ice40_reset_sequencer #(
  parameter int NUM_STAGES  = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 4,
  parameter int WDT_CYCLES  = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sw_req,
  input  logic                  ext_req,
  input  logic                  wdt_kick,
  output logic [NUM_STAGES-1:0] stage_resetn,
  output logic                  busy,
  output logic [1:0]            cause
);

  localparam int MAX_HG  = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int MAX_CNT = (MAX_HG > WDT_CYCLES) ? MAX_HG : WDT_CYCLES;
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
  localparam int SIDX_W  = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  localparam logic [1:0] CAUSE_POR = 2'b00;
  localparam logic [1:0] CAUSE_SW  = 2'b01;
  localparam logic [1:0] CAUSE_EXT = 2'b10;
  localparam logic [1:0] CAUSE_WDT = 2'b11;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  // Reset asserts immediately but leaves only on a clock edge.
  logic rst_meta_q;
  logic rst_sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= 1'b1;
    end else begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= rst_meta_q;
    end
  end

  logic ext_meta_q;
  logic ext_sync_q;

  always_ff @(posedge clk or posedge rst_sync_q) begin
    if (rst_sync_q) begin
      ext_meta_q <= 1'b0;
      ext_sync_q <= 1'b0;
    end else begin
      ext_meta_q <= ext_req;
      ext_sync_q <= ext_meta_q;
    end
  end

  state_t                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [SIDX_W-1:0]       stage_idx_q;
  logic [NUM_STAGES-1:0]   stage_resetn_q;
  logic                    busy_q;
  logic [1:0]              cause_q;
  logic                    wdt_expire;

`ifdef ICE40_RESET_WDT_EN
  logic [CNT_W-1:0] wdt_cnt_q;

  assign wdt_expire = (state_q == ST_RUN) && !wdt_kick &&
                      (wdt_cnt_q == CNT_W'(WDT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst_sync_q) begin
    if (rst_sync_q) begin
      wdt_cnt_q <= '0;
    end else if ((state_q != ST_RUN) || wdt_kick || wdt_expire) begin
      wdt_cnt_q <= '0;
    end else begin
      wdt_cnt_q <= wdt_cnt_q + CNT_W'(1);
    end
  end
`else
  logic wdt_kick_unused;

  assign wdt_kick_unused = wdt_kick;
  assign wdt_expire      = 1'b0;
`endif

  logic       req_any;
  logic [1:0] cause_d;

  always_comb begin
    req_any = sw_req || ext_sync_q || wdt_expire;
    cause_d = CAUSE_SW;
    if (wdt_expire) begin
      cause_d = CAUSE_WDT;
    end else if (ext_sync_q) begin
      cause_d = CAUSE_EXT;
    end
  end

  always_ff @(posedge clk or posedge rst_sync_q) begin
    if (rst_sync_q) begin
      state_q        <= ST_HOLD;
      cnt_q          <= '0;
      stage_idx_q    <= '0;
      stage_resetn_q <= '0;
      busy_q         <= 1'b1;
      cause_q        <= CAUSE_POR;
    end else if (req_any) begin
      // Any accepted request restarts the whole sequence, even mid-release.
      state_q        <= ST_HOLD;
      cnt_q          <= '0;
      stage_idx_q    <= '0;
      stage_resetn_q <= '0;
      busy_q         <= 1'b1;
      cause_q        <= cause_d;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
            cnt_q       <= '0;
            stage_idx_q <= '0;
            if (NUM_STAGES == 1) begin
              stage_resetn_q <= '1;
              busy_q         <= 1'b0;
              state_q        <= ST_RUN;
            end else begin
              stage_resetn_q <= NUM_STAGES'(1);
              state_q        <= ST_RELEASE;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          if (cnt_q == CNT_W'(STAGE_GAP - 1)) begin
            cnt_q          <= '0;
            stage_resetn_q <= (stage_resetn_q << 1) | NUM_STAGES'(1);
            stage_idx_q    <= stage_idx_q + SIDX_W'(1);
            if (stage_idx_q == SIDX_W'(NUM_STAGES - 2)) begin
              busy_q  <= 1'b0;
              state_q <= ST_RUN;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_RUN: begin
          stage_resetn_q <= '1;
          busy_q         <= 1'b0;
        end
        default: begin
          state_q        <= ST_HOLD;
          cnt_q          <= '0;
          stage_resetn_q <= '0;
          busy_q         <= 1'b1;
        end
      endcase
    end
  end

  assign stage_resetn = stage_resetn_q;
  assign busy         = busy_q;
  assign cause        = cause_q;

endmodule

// File: doc/ice40_reset_sequencer.md
# ice40_reset_sequencer

Central reset controller for the iCE40 design. Takes the board power-on reset and reset requests from on-chip requesters: the SPI slave command decoder (synchronous) and an external pin (asynchronous). It asserts all downstream reset domains together, holds them for a fixed time, then releases them one stage at a time in a fixed order. It reports the cause of the last reset and replaces ad-hoc per-block power-on counters.

## Interface
Parameters:
- NUM_STAGES, 3: number of reset domains released in sequence; legal range 1..8.
- HOLD_CYCLES, 16: cycles all domains are held in reset after the last accepted request; ≥1.
- STAGE_GAP, 4: cycles between consecutive stage releases; ≥1.
- WDT_CYCLES, 1024: watchdog timeout in cycles; ≥2. Used only with ICE40_RESET_WDT_EN.

Ports:
- clk, input, 1: single system clock.
- reset, input, 1: one clock; reset is asynchronous and active-high. Asserts asynchronously; deassertion passes through an internal 2-flop synchronizer.
- sw_req, input, 1: synchronous reset request from the command decoder; sampled every edge.
- ext_req, input, 1: asynchronous reset request; internal 2-flop synchronizer.
- wdt_kick, input, 1: watchdog restart pulse.
- stage_resetn, output, NUM_STAGES: active-low domain resets; bit 0 releases first.
- busy, output, 1: high while any stage_resetn bit is low.
- cause, output, 2: cause of the last reset. Values: 00 POR, 01 sw_req, 10 ext_req, 11 watchdog.

## Operation
- FSM states: HOLD, RELEASE, RUN. All outputs are registered.
- Reset values: state HOLD, stage_resetn all 0, busy 1, cause 00, all counters 0.
- HOLD:
  - The counter increments each cycle.
  - When it reaches HOLD_CYCLES-1, go to RELEASE and set stage_resetn[0]=1 on that edge; stage index = 0, counter cleared.
- RELEASE:
  - The counter counts to STAGE_GAP-1, then releases the next stage and clears the counter.
  - Releasing the last stage (index NUM_STAGES-1) moves to RUN; busy falls on that same edge.
  - With NUM_STAGES=1, HOLD goes straight to RUN.
- RUN: idle; all stage_resetn are 1.
- Request acceptance, any state:
  - A sampled request (sw_req, or synchronized ext_req, or watchdog expiry) moves the FSM to HOLD.
  - On that edge: all stage_resetn go to 0, busy goes to 1, the counter clears, and cause updates.
- Simultaneous requests set cause by priority: watchdog > ext > sw.
- A request that stays high keeps the FSM in HOLD. The counter clears each cycle, so the hold stretches until HOLD_CYCLES after the request drops.
- A request during RELEASE re-asserts every stage, including stages already released.
- POR (reset) overrides everything; it is the only way cause becomes 00.
- Counter width is $clog2 of the maximum of HOLD_CYCLES, STAGE_GAP and WDT_CYCLES. Stage index width is $clog2(NUM_STAGES), minimum 1. Counters never wrap.

## Timing
- Edge numbering: E0 is the first rising edge after reset deasserts.
  - Synchronizer clears on E1, so HOLD counts from E2.
  - stage_resetn[0] rises on edge E(1+HOLD_CYCLES).
  - stage_resetn[k] rises k*STAGE_GAP edges after stage 0.
- sw_req high before edge N: stage_resetn all 0 and busy 1 after edge N (1-cycle latency).
- ext_req: add 2 cycles of synchronizer latency.
- Re-release after a one-cycle request at edge N: stage 0 rises at N+HOLD_CYCLES.
- stage_resetn is glitch-free: each bit comes straight from a flop.

## Configuration
- ICE40_RESET_WDT_EN defined:
  - A watchdog counter runs only in RUN.
  - wdt_kick clears it. It is also cleared when the FSM leaves RUN.
  - When the count reaches WDT_CYCLES-1 without a kick, it raises an internal one-cycle request with cause 11.
- ICE40_RESET_WDT_EN undefined:
  - No watchdog logic is built; wdt_kick is ignored.
  - cause never reads 11.
  - The port list is identical in both builds.

## Test plan
- POR with defaults: reset deasserts before E0 → stage_resetn[0] rises at E17, [1] at E21, [2] at E25; busy falls at E25; cause=00.
- One-cycle sw_req in RUN at edge N → stage_resetn=000 and busy=1 after N; stage 0 rises at N+16; cause=01.
- ext_req pulse of 3 cycles mid-RELEASE (stage 0 already released) → all stages back to 0 by ext edge+3; full sequence restarts; cause=10.
- sw_req and ext_req arriving on the same sampled edge → cause=10. sw_req held 40 cycles → stage 0 rises 16 edges after the last high sample.
- reset asserted mid-RELEASE → outputs immediately 000/busy 1/cause 00 without waiting for clk; sequence repeats as in the POR case.
- ICE40_RESET_WDT_EN with WDT_CYCLES=8: kicking every 5 cycles → no reset. Stopping kicks → stages go low 8 cycles after the last kick; cause=11.
